// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: pipeline register between the fetch and decode stages.
// Handles load-use stalls, flushes on resolved jumps/branches, memory-latency
// bubbles, and freezes fetch once a valid HALT reaches decode.
// Optional macro FD_STALL_COUNT_EN builds saturating stall/flush counters;
// without it both counters read as zero and no counter flops exist.
module fetch_decode_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeFD,
    input  logic        flushFD,
    input  logic [15:0] F_inst,
    input  logic [15:0] F_pcPlus2,
    input  logic        F_valid,
    output logic        F_ready,
    output logic [15:0] D_inst,
    output logic [15:0] D_pcPlus2,
    output logic        D_valid,
    output logic        D_halting,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount
);

    localparam logic [15:0] NOP_INST = 16'h0800;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fd_state_t;

    fd_state_t   state;
    fd_state_t   state_next;
    logic [15:0] inst_q;
    logic [15:0] inst_next;
    logic [15:0] pc_q;
    logic [15:0] pc_next;
    logic        valid_q;
    logic        valid_next;
    logic        is_halt;

    // A HALT is any instruction whose opcode field [15:11] is all zero.
    assign is_halt = (F_inst[15:11] == 5'b00000);

    // Fetch may only hand over an instruction when we are running, not stalled,
    // not being flushed and not in reset; fetch holds its PC otherwise.
    assign F_ready   = writeFD & ~flushFD & (state == RUN) & ~rst;
    assign D_inst    = inst_q;
    assign D_pcPlus2 = pc_q;
    assign D_valid   = valid_q;
    assign D_halting = (state == HALTED);

    // Next-state and next-contents, priority flush > halted hold > stall > load.
    always_comb begin
        state_next = state;
        inst_next  = inst_q;
        pc_next    = pc_q;
        valid_next = valid_q;
        if (flushFD) begin
            inst_next  = NOP_INST;
            pc_next    = F_pcPlus2;
            valid_next = 1'b0;
            state_next = RUN;
        end else if (state == HALTED) begin
            state_next = HALTED;
        end else if (!writeFD) begin
            state_next = RUN;
        end else if (F_valid) begin
            inst_next  = F_inst;
            pc_next    = F_pcPlus2;
            valid_next = 1'b1;
            state_next = is_halt ? HALTED : RUN;
        end else begin
            inst_next  = NOP_INST;
            valid_next = 1'b0;
        end
    end

    // Pipeline register and FSM state, with synchronous reset to an empty RUN slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            inst_q  <= NOP_INST;
            pc_q    <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            inst_q  <= inst_next;
            pc_q    <= pc_next;
            valid_q <= valid_next;
        end
    end

`ifdef FD_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating performance counters: stalls only count while running and not flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (!flushFD && (state == RUN) && !writeFD && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flushFD && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;
`else
    assign stallCount = 16'h0000;
    assign flushCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb_fetch_decode_reg: directed plus randomized bench for fetch_decode_reg,
// checked against a cycle-level behavioural model of the register's rules.
// Define FD_STALL_COUNT_EN for both files to exercise the counters.
module tb_fetch_decode_reg;

    logic        clk;
    logic        rst;
    logic        writeFD;
    logic        flushFD;
    logic [15:0] F_inst;
    logic [15:0] F_pcPlus2;
    logic        F_valid;
    logic        F_ready;
    logic [15:0] D_inst;
    logic [15:0] D_pcPlus2;
    logic        D_valid;
    logic        D_halting;
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_inst;
    logic [15:0] m_pc;
    logic        m_valid;
    logic        m_halted;
    int          m_stall;
    int          m_flush;

    fetch_decode_reg dut (
        .clk        (clk),
        .rst        (rst),
        .writeFD    (writeFD),
        .flushFD    (flushFD),
        .F_inst     (F_inst),
        .F_pcPlus2  (F_pcPlus2),
        .F_valid    (F_valid),
        .F_ready    (F_ready),
        .D_inst     (D_inst),
        .D_pcPlus2  (D_pcPlus2),
        .D_valid    (D_valid),
        .D_halting  (D_halting),
        .stallCount (stallCount),
        .flushCount (flushCount)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic modelEdge();
        if (rst) begin
            m_inst = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0;
            m_halted = 1'b0;   m_stall = 0;     m_flush = 0;
        end else begin
            if (flushFD) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            else if (!m_halted && !writeFD) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (flushFD) begin
                m_inst = 16'h0800; m_valid = 1'b0; m_pc = F_pcPlus2; m_halted = 1'b0;
            end else if (m_halted || !writeFD) begin
                // everything holds
            end else if (F_valid) begin
                m_inst = F_inst; m_pc = F_pcPlus2; m_valid = 1'b1;
                m_halted = (F_inst[15:11] == 5'b00000);
            end else begin
                m_inst = 16'h0800; m_valid = 1'b0;
            end
        end
    endtask

    task automatic checkOutput();
        logic [15:0] exp_stall;
        logic [15:0] exp_flush;
`ifdef FD_STALL_COUNT_EN
        exp_stall = 16'(m_stall);
        exp_flush = 16'(m_flush);
`else
        exp_stall = 16'h0000;
        exp_flush = 16'h0000;
`endif
        check("D_inst",     D_inst,            m_inst);
        check("D_pcPlus2",  D_pcPlus2,         m_pc);
        check("D_valid",    {15'd0, D_valid},  {15'd0, m_valid});
        check("D_halting",  {15'd0, D_halting}, {15'd0, m_halted});
        check("stallCount", stallCount,        exp_stall);
        check("flushCount", flushCount,        exp_flush);
    endtask

    // Drive one cycle of inputs, check F_ready combinationally, then clock and check.
    task automatic applyStimulus(input logic r, input logic wr, input logic fl,
                                 input logic [15:0] inst, input logic [15:0] pc,
                                 input logic fv);
        logic exp_ready;
        rst = r; writeFD = wr; flushFD = fl; F_inst = inst; F_pcPlus2 = pc; F_valid = fv;
        #2;
        exp_ready = wr & ~fl & ~m_halted & ~r;
        check("F_ready", {15'd0, F_ready}, {15'd0, exp_ready});
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        m_inst = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0;
        m_halted = 1'b0;   m_stall = 0;     m_flush = 0;
        rst = 1'b1; writeFD = 1'b0; flushFD = 1'b0;
        F_inst = 16'h0000; F_pcPlus2 = 16'h0000; F_valid = 1'b0;
        #1;

        // Reset with busy inputs, then a plain load
        applyStimulus(1, 1, 0, 16'hABCD, 16'h1234, 1);
        applyStimulus(0, 1, 0, 16'hD0A4, 16'h0012, 1);
        // Three stall cycles hold the instruction
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 16'h1111, 16'h0014, 1);
        // Flush overrides stall
        applyStimulus(0, 0, 1, 16'h2222, 16'h0020, 1);
        // HALT, ignored loads, flush out of HALTED
        applyStimulus(0, 1, 0, 16'h0000, 16'h0022, 1);
        applyStimulus(0, 1, 0, 16'h5555, 16'h0024, 1);
        applyStimulus(0, 0, 0, 16'h6666, 16'h0026, 1);
        applyStimulus(0, 1, 1, 16'h7777, 16'h0040, 1);
        // Memory-latency bubble
        applyStimulus(0, 1, 0, 16'h3333, 16'h0042, 1);
        applyStimulus(0, 1, 0, 16'h4444, 16'h0044, 0);
        // Halt with a non-zero low field, then reset while halted
        applyStimulus(0, 1, 0, 16'h07FF, 16'h0046, 1);
        applyStimulus(1, 1, 0, 16'h9999, 16'h0048, 1);
        // Reset mid-stall
        applyStimulus(0, 0, 0, 16'h1234, 16'h0050, 1);
        applyStimulus(1, 0, 0, 16'h1234, 16'h0050, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] inst;
            inst = 16'($urandom);
            if ($urandom_range(0, 7) == 0) inst[15:11] = 5'b00000;
            applyStimulus(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0), inst, 16'($urandom),
                          ($urandom_range(0, 4) != 0));
        end

        // Long stall run drives the stall counter into saturation
        applyStimulus(1, 0, 0, 16'h0000, 16'h0000, 0);
        for (int i = 0; i < 70000; i++) applyStimulus(0, 0, 0, 16'h1111, 16'h0002, 1);
        applyStimulus(0, 0, 0, 16'h1111, 16'h0002, 1);
        applyStimulus(0, 0, 1, 16'h1111, 16'h0004, 1);
        applyStimulus(0, 1, 0, 16'hD0A4, 16'h0006, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_reg.md
FETCH_DECODE_REG -- requirements
Module: fetch_decode_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port writeFD, input, 1 bit: 1 = register may advance; 0 = hold (load-use stall from hazard unit).
REQ-004 SHALL have port flushFD, input, 1 bit: 1 = discard contents (taken jump/branch resolved downstream).
REQ-005 SHALL have port F_inst, input, 16 bits: fetched instruction.
REQ-006 SHALL have port F_pcPlus2, input, 16 bits: PC+2 of the fetched instruction.
REQ-007 SHALL have port F_valid, input, 1 bit: 1 = instruction memory returned F_inst this cycle.
REQ-008 SHALL have port F_ready, output, 1 bit: 1 = this register accepts F_inst this cycle; fetch holds its PC when 0.
REQ-009 SHALL have port D_inst, output, 16 bits: instruction presented to decode.
REQ-010 SHALL have port D_pcPlus2, output, 16 bits: PC+2 presented to decode.
REQ-011 SHALL have port D_valid, output, 1 bit: 1 = D_inst is a real instruction, not a bubble.
REQ-012 SHALL have port D_halting, output, 1 bit: 1 = a valid HALT is held and fetch is frozen.
REQ-013 SHALL have port stallCount, output, 16 bits: count of cycles held by writeFD=0.
REQ-014 SHALL have port flushCount, output, 16 bits: count of cycles with flushFD=1.

Function
REQ-015 SHALL define NOP as 16'h0800 and HALT as any instruction with bits [15:11]=5'b00000.
REQ-016 SHALL implement FSM states RUN and HALTED, entering RUN on reset.
REQ-017 SHALL apply per-cycle priority rst > flushFD > HALTED hold > writeFD=0 hold > load.
REQ-018 SHALL, on flushFD=1 in any state, load D_inst=NOP, D_valid=0, D_pcPlus2=F_pcPlus2, and go to RUN.
REQ-019 SHALL, in RUN with writeFD=0 and flushFD=0, keep D_inst, D_pcPlus2 and D_valid unchanged.
REQ-020 SHALL, in RUN with writeFD=1 and F_valid=1, load D_inst=F_inst, D_pcPlus2=F_pcPlus2, D_valid=1.
REQ-021 SHALL, in RUN with writeFD=1 and F_valid=0, load D_inst=NOP and D_valid=0 (memory-latency bubble); D_pcPlus2 holds.
REQ-022 SHALL go RUN->HALTED on the edge that loads a HALT with D_valid=1; in HALTED it SHALL hold all outputs until flushFD or rst.
REQ-023 SHALL drive F_ready = writeFD & ~flushFD & (state==RUN) combinationally, with zero-cycle latency.
REQ-024 SHALL drive D_halting = (state==HALTED).
REQ-025 SHALL give a one-cycle latency from F_inst accepted to D_inst visible.
REQ-026 SHALL, when flushFD=1 and writeFD=0 occur together, perform the flush; the flush overrides the stall.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, set D_inst=16'h0800, D_pcPlus2=16'h0000, D_valid=0, state=RUN, stallCount=0, flushCount=0, regardless of other inputs.
REQ-028 SHALL, with rst asserted mid-stall or in HALTED, return to RUN on that edge.
REQ-029 SHALL drive F_ready=0 while rst=1.

Configuration
REQ-030 SHALL compile counters only when macro FD_STALL_COUNT_EN is defined.
REQ-031 SHALL, with FD_STALL_COUNT_EN defined, increment stallCount each cycle with RUN, writeFD=0, flushFD=0, rst=0.
REQ-032 SHALL, with FD_STALL_COUNT_EN defined, increment flushCount each cycle with flushFD=1 and rst=0.
REQ-033 SHALL saturate both counters at 16'hFFFF with no wrap.
REQ-034 SHALL, without FD_STALL_COUNT_EN, tie stallCount and flushCount to 16'h0000 and include no counter flops.

Verification
REQ-035 Load: writeFD=1, F_valid=1, F_inst=16'hD0A4, F_pcPlus2=16'h0012 -> next cycle D_inst=16'hD0A4, D_pcPlus2=16'h0012, D_valid=1.
REQ-036 Stall: after REQ-035, writeFD=0 for 3 cycles with F_inst=16'h1111 -> D_inst stays 16'hD0A4; F_ready=0; stallCount=3 (macro on).
REQ-037 Flush beats stall: writeFD=0, flushFD=1 -> next cycle D_inst=16'h0800, D_valid=0, flushCount=1.
REQ-038 Halt: load F_inst=16'h0000 valid -> D_halting=1, F_ready=0; further loads ignored; flushFD=1 -> D_halting=0, D_inst=16'h0800.
REQ-039 Bubble and reset: writeFD=1, F_valid=0 -> D_inst=16'h0800, D_valid=0; rst=1 in HALTED -> all REQ-027 values next edge.
REQ-040 Saturation: preload via 70000 stall cycles -> stallCount=16'hFFFF and holds; macro off -> both counters 0 throughout.
